// File: rtl/serial_sub.sv
// Bit-serial ripple-borrow subtractor: d = a - b - bin, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to produce the two's-complement overflow flag; otherwise ovf is 0.
module serial_sub #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] d,
   output logic         bout,
   output logic         ovf
);

   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [W-1:0]  sa;
   logic [W-1:0]  sb;
   logic [W-1:0]  sd;
   logic          br;
   logic [CW-1:0] cnt;

   logic          diff;
   logic          br_next;
   logic [W-1:0]  sd_next;

`ifdef SERIAL_SUB_OVF_EN
   // Borrow into the bit currently being processed; at the last bit this is the borrow into the MSB.
   logic br_msb;
   always_comb begin
      br_msb = br;
   end
`endif

   // One full-subtractor cell fed by the LSBs of the operand shift registers.
   always_comb begin
      diff    = sa[0] ^ sb[0] ^ br;
      br_next = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);
      sd_next = {diff, sd[W-1:1]};
   end

   // Control FSM and datapath; results are only written on the completing edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         sd    <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         d     <= '0;
         bout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  sd    <= '0;
                  br    <= bin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               sd  <= sd_next;
               br  <= br_next;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(W - 1)) begin
                  d     <= sd_next;
                  bout  <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                  ovf   <= br_msb ^ br_next;
`else
                  ovf   <= 1'b0;
`endif
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard testbench for serial_sub at W=8 using directed vectors.
// Expected ovf for the overflow vector follows SERIAL_SUB_OVF_EN.
module tb_serial_sub;

   localparam int W = 8;

`ifdef SERIAL_SUB_OVF_EN
   localparam logic OVF_80 = 1'b1;
`else
   localparam logic OVF_80 = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         bout;
   logic         ovf;

   typedef struct {
      logic [W-1:0] d;
      logic         bout;
      logic         ovf;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;

   serial_sub #(.W(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .bin  (bin),
      .busy (busy),
      .done (done),
      .d    (d),
      .bout (bout),
      .ovf  (ovf)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                                input logic push, input logic [W-1:0] ed, input logic eb,
                                input logic eo);
      exp_t e;
      a     = av;
      b     = bv;
      bin   = bi;
      start = 1'b1;
      if (push) begin
         e.d    = ed;
         e.bout = eb;
         e.ovf  = eo;
         sb_q.push_back(e);
      end
      tick();
      start = 1'b0;
   endtask

   task automatic waitDone(input string name);
      int n;
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      checkOutput(name, 64'(done), 64'd1);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            checkOutput("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            checkOutput("result_d", 64'(d), 64'(e.d));
            checkOutput("result_bout", 64'(bout), 64'(e.bout));
            checkOutput("result_ovf", 64'(ovf), 64'(e.ovf));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_done", 64'(done), 64'd0);
      checkOutput("reset_d", 64'(d), 64'd0);
      checkOutput("reset_bout", 64'(bout), 64'd0);
      checkOutput("reset_ovf", 64'(ovf), 64'd0);

      // 5 - 3 with cycle-accurate busy/done checks
      applyStimulus(8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
      for (int i = 1; i <= W; i++) begin
         checkOutput($sformatf("busy_c%0d", i), 64'(busy), 64'd1);
         checkOutput($sformatf("done_c%0d", i), 64'(done), 64'd0);
         tick();
      end
      checkOutput("done_c9", 64'(done), 64'd1);
      checkOutput("busy_c9", 64'(busy), 64'd0);
      tick();
      checkOutput("done_pulse_width", 64'(done), 64'd0);

      applyStimulus(8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0);
      waitDone("done_3m5");
      tick();

      applyStimulus(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, OVF_80);
      waitDone("done_80m1");
      tick();

      applyStimulus(8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
      waitDone("done_0m0b1");
      tick();

      // Back-to-back: mid-RUN start ignored, DONE-cycle start accepted
      applyStimulus(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      applyStimulus(8'h20, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 5; i < 9; i++) tick();
      checkOutput("b2b_done_c9", 64'(done), 64'd1);
      applyStimulus(8'h20, 8'h02, 1'b0, 1'b1, 8'h1E, 1'b0, 1'b0);
      for (int i = 10; i < 17; i++) tick();
      checkOutput("b2b_done_c17", 64'(done), 64'd0);
      tick();
      checkOutput("b2b_done_c18", 64'(done), 64'd1);
      tick();

      // Reset aborts an operation in cycle 5
      applyStimulus(8'h55, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 1; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_done", 64'(done), 64'd0);
      checkOutput("abort_d", 64'(d), 64'd0);
      checkOutput("abort_bout", 64'(bout), 64'd0);
      checkOutput("abort_ovf", 64'(ovf), 64'd0);
      tick();
      checkOutput("abort_done_c7", 64'(done), 64'd0);
      applyStimulus(8'h55, 8'h11, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0);
      waitDone("done_after_abort");
      tick();
      tick();

      checkOutput("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
